// File: rtl/mysystem_mem_pkg.sv
// mysystem_mem_pkg: shared FSM encoding and test-pattern function for the RAM checker
package mysystem_mem_pkg;
    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, FIN} state_t;
    function automatic logic [31:0] pattern(input logic [31:0] seed, input logic [15:0] i);
        return seed ^ {i, ~i};
    endfunction
endpackage

// File: rtl/mysystem_mem_pattern.sv
// mysystem_mem_pattern: combinational P(i) generator; ports seed, idx (word index) -> data
module mysystem_mem_pattern
    import mysystem_mem_pkg::*;
#(
    parameter int IDX_W = 12
) (
    input  logic [31:0]      seed,
    input  logic [IDX_W-1:0] idx,
    output logic [31:0]      data
);
    assign data = pattern(seed, 16'(idx));
endmodule

// File: rtl/mysystem_mem_checker.sv
// mysystem_mem_checker: Avalon-MM write/read-back BIST master for the mysystem RAM.
// Ports: clk, reset_n (async, active low); start/base_addr/word_count/seed request a test;
// busy/done/pass/err_count/first_err_addr report it; avm_* is the Avalon-MM master side.
module mysystem_mem_checker
    import mysystem_mem_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic [BE_W-1:0]   avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic              avm_read,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid
);
    state_t            state, next;
    logic [ADDR_W:0]   idx, cnt_q;
    logic [ADDR_W-1:0] base_q, addr;
    logic [DATA_W-1:0] seed_q, pat;
    logic              pass_q, last;

    mysystem_mem_pattern #(.IDX_W(ADDR_W + 1)) u_pat (.seed(seed_q), .idx(idx), .data(pat));

    assign addr = base_q + idx[ADDR_W-1:0];
    assign last = idx == cnt_q - 1'b1;

    // Bus strobes are decoded from state, so an async reset drops them immediately.
    assign busy           = state inside {WR, RD_REQ, RD_WAIT};
    assign done           = state == FIN;
    assign pass           = done ? err_count == '0 : pass_q;
    assign avm_write      = state == WR;
    assign avm_read       = state == RD_REQ;
    assign avm_chipselect = avm_write | avm_read;
    assign avm_byteenable = {BE_W{avm_chipselect}};
    assign avm_address    = avm_chipselect ? addr : '0;
    assign avm_writedata  = avm_write ? pat : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = word_count == '0 ? FIN : WR;
            WR:      if (!avm_waitrequest && last) next = RD_REQ;
            RD_REQ:  if (!avm_waitrequest) next = RD_WAIT;
            RD_WAIT: if (avm_readdatavalid) next = last ? FIN : RD_REQ;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx            <= '0;
            cnt_q          <= '0;
            base_q         <= '0;
            seed_q         <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base_q         <= base_addr;
                    cnt_q          <= word_count;
                    seed_q         <= seed;
                    idx            <= '0;
                    err_count      <= '0;
                    first_err_addr <= '0;
                    pass_q         <= 1'b0;
                end
                WR: if (!avm_waitrequest) idx <= last ? '0 : idx + 1'b1;
                RD_WAIT: if (avm_readdatavalid) begin
                    if (avm_readdata != pat) begin
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        if (err_count == '0) first_err_addr <= addr;
                    end
                    idx <= idx + 1'b1;
                end
                FIN: pass_q <= err_count == '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mysystem_mem_checker.sv
// tb_mysystem_mem_checker: vector table + scoreboard bench with a 2048x32 RAM model
module tb_mysystem_mem_checker;
    logic        clk = 0, reset_n = 0, start = 0;
    logic [10:0] base_addr = 0, first_err_addr, avm_address;
    logic [11:0] word_count = 0;
    logic [31:0] seed = 0, avm_writedata, avm_readdata;
    logic        busy, done, pass, avm_chipselect, avm_write, avm_read;
    logic [15:0] err_count;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 0, avm_readdatavalid;

    mysystem_mem_checker dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr), .avm_address(avm_address),
        .avm_byteenable(avm_byteenable), .avm_chipselect(avm_chipselect),
        .avm_write(avm_write), .avm_read(avm_read), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // RAM model: 1-cycle read latency, optional bit0 corruption on reads of 100 and 200.
    logic [31:0] ram [2048];
    bit flip_en = 0, stall_en = 0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_readdatavalid <= 0;
            avm_readdata <= 0;
        end else begin
            avm_readdatavalid <= 0;
            if (avm_write && !avm_waitrequest) ram[avm_address] <= avm_writedata;
            if (avm_read && !avm_waitrequest) begin
                avm_readdatavalid <= 1;
                avm_readdata <= ram[avm_address] ^
                    {31'd0, flip_en && (avm_address == 11'd100 || avm_address == 11'd200)};
            end
        end
    end

    always @(negedge clk) avm_waitrequest = stall_en ? 1'($urandom_range(1)) : 1'b0;

    // Bus protocol monitor: stability under stall, exclusive strobes, chipselect/byteenable.
    int cyc = 0, stab_err = 0, strobes = 0;
    bit held = 0;
    logic [10:0] h_addr;
    logic [31:0] h_data;
    logic h_w, h_r;
    always @(posedge clk) begin
        cyc++;
        if (!reset_n) held = 0;
        else begin
            if (held && (avm_address != h_addr || avm_writedata != h_data ||
                         avm_write != h_w || avm_read != h_r)) stab_err++;
            if (avm_write && avm_read) stab_err++;
            if (avm_chipselect != (avm_write | avm_read)) stab_err++;
            if ((avm_write | avm_read) && avm_byteenable != 4'hF) stab_err++;
            if (avm_write | avm_read) strobes++;
            held = (avm_write | avm_read) && avm_waitrequest;
            h_addr = avm_address; h_data = avm_writedata; h_w = avm_write; h_r = avm_read;
        end
    end

    typedef struct { bit pass; logic [15:0] err; logic [10:0] first; int lat; } exp_t;
    exp_t sb[$];
    int start_t = 0;
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) chk(0, "unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk(pass == e.pass, "pass", pass, e.pass);
                chk(err_count == e.err, "err_count", err_count, e.err);
                chk(first_err_addr == e.first, "first_err_addr", first_err_addr, e.first);
                if (e.lat >= 0) chk(cyc - start_t == e.lat, "done_latency", cyc - start_t, e.lat);
            end
        end
    end

    typedef struct {
        logic [10:0] base; logic [11:0] cnt; logic [31:0] seed;
        bit flip; bit stall; bit exp_pass; logic [15:0] exp_err; logic [10:0] exp_first;
    } vec_t;
    vec_t vecs[7];

    function automatic int ram_bad(input logic [31:0] s);
        int bad = 0;
        for (int i = 0; i < 2048; i++)
            if (ram[i] != (s ^ {16'(i), ~16'(i)})) bad++;
        return bad;
    endfunction

    task automatic run(input vec_t v);
        exp_t e;
        @(negedge clk);
        base_addr = v.base; word_count = v.cnt; seed = v.seed;
        flip_en = v.flip; stall_en = v.stall; strobes = 0; stab_err = 0;
        e.pass = v.exp_pass; e.err = v.exp_err; e.first = v.exp_first;
        e.lat = v.stall ? -1 : 3 * int'(v.cnt) + 1;
        sb.push_back(e);
        start = 1; start_t = cyc;
        @(negedge clk);
        start = 0;
        for (int n = 0; n < 40000 && sb.size() != 0; n++) @(negedge clk);
        chk(sb.size() == 0, "done_timeout", sb.size(), 0);
        sb.delete();
        chk(stab_err == 0, "bus_protocol", stab_err, 0);
        stall_en = 0;
    endtask

    initial begin
        logic [10:0] a0;
        vecs[0] = '{11'd0,    12'd2048, 32'h0,        0, 0, 1, 16'd0, 11'd0};
        vecs[1] = '{11'd2040, 12'd16,   32'hA5A5A5A5, 0, 0, 1, 16'd0, 11'd0};
        vecs[2] = '{11'd0,    12'd512,  32'h12345678, 1, 0, 0, 16'd2, 11'd100};
        vecs[3] = '{11'd5,    12'd0,    32'h0,        0, 0, 1, 16'd0, 11'd0};
        vecs[4] = '{11'd50,   12'd200,  32'hFFFFFFFF, 1, 0, 0, 16'd2, 11'd100};
        vecs[5] = '{11'd1000, 12'd1,    32'hDEADBEEF, 0, 0, 1, 16'd0, 11'd0};
        vecs[6] = '{11'd0,    12'd2048, 32'h0,        0, 1, 1, 16'd0, 11'd0};

        repeat (3) @(negedge clk);
        chk({busy, done, pass, err_count, first_err_addr, avm_chipselect, avm_write,
             avm_read, avm_address, avm_byteenable, avm_writedata} == '0, "reset_outputs", 1, 0);
        reset_n = 1;

        for (int k = 0; k < 7; k++) begin
            run(vecs[k]);
            if (k == 0) begin
                chk(ram[5] == 32'h0005FFFA, "ram5", ram[5], 32'h0005FFFA);
                chk(ram_bad(0) == 0, "ram_image", ram_bad(0), 0);
            end
            if (k == 1) begin
                chk(ram[2047] == 32'hA5A25A5D, "ram2047", ram[2047], 32'hA5A25A5D);
                chk(ram[0] == 32'hA5AD5A52, "ram0_wrap", ram[0], 32'hA5AD5A52);
                chk(ram[8] == 32'h0008FFF7, "ram8_untouched", ram[8], 32'h0008FFF7);
            end
            if (k == 3) chk(strobes == 0, "zero_count_strobes", strobes, 0);
            if (k == 6) chk(ram_bad(0) == 0, "ram_image_stall", ram_bad(0), 0);
        end

        // Start pulses while busy are ignored, then reset mid-WR kills strobes at once.
        @(negedge clk);
        base_addr = 0; word_count = 64; seed = 32'h0F0F0F0F; start = 1;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        a0 = avm_address;
        base_addr = 11'd999; word_count = 1; start = 1;
        @(negedge clk);
        start = 0;
        chk(avm_address == a0 + 11'd1 && avm_write, "start_ignored_busy", avm_address, a0 + 11'd1);
        repeat (3) @(negedge clk);
        #2 reset_n = 0;
        #1 chk({avm_write, avm_read, avm_chipselect, avm_byteenable, busy, done} == '0,
               "async_reset_strobes", {avm_write, avm_read, avm_chipselect, busy}, 0);
        @(negedge clk);
        reset_n = 1;

        // A start coinciding with the done cycle is ignored.
        begin
            exp_t e;
            @(negedge clk);
            base_addr = 11'd300; word_count = 2; seed = 32'h0; start = 1; start_t = cyc;
            e.pass = 1; e.err = 0; e.first = 0; e.lat = 7;
            sb.push_back(e);
            @(negedge clk);
            start = 0;
            for (int n = 0; n < 100 && !done; n++) @(negedge clk);
            chk(done == 1, "fin_reached", done, 1);
            start = 1; word_count = 5;
            @(negedge clk);
            start = 0;
            chk(busy == 0 && done == 0, "fin_start_ignored", busy, 0);
            repeat (20) @(negedge clk);
            chk(busy == 0 && sb.size() == 0, "idle_after_fin", busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
